// File: rtl/data_mem_ctrl.sv
// Data RAM initiator: converts MEM-stage load/store requests into RAM strobes
// with programmable wait states and returns aligned, extended load data.
module data_mem_ctrl #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_req,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic          we;
        logic [1:0]    size;
        logic          sgn;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    // Size 11 and misaligned halfword/word accesses never touch the RAM.
    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Big-endian lanes: sel[3] covers byte offset 0 (bits 31:24).
    function automatic logic [SEL_W-1:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        logic [SEL_W-1:0] sel;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    sel = 4'b1000;
                    2'd1:    sel = 4'b0100;
                    2'd2:    sel = 4'b0010;
                    default: sel = 4'b0001;
                endcase
            end
            SZ_HALF: sel = off[1] ? 4'b0011 : 4'b1100;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [DW-1:0] lane_data(input logic [1:0] size, input logic [DW-1:0] wdata);
        logic [DW-1:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] word,
                                                   input logic [1:0]    size,
                                                   input logic [1:0]    off,
                                                   input logic          sgn);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    req_t              req_in;
    req_t              cur;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DW-1:0]     resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              ram_ce_q, ram_ce_d;
    logic              ram_we_q, ram_we_d;
    logic [AW-1:0]     ram_addr_q, ram_addr_d;
    logic [SEL_W-1:0]  ram_sel_q, ram_sel_d;
    logic [DW-1:0]     ram_data_q, ram_data_d;

    always_comb begin
        req_in.we    = req_we;
        req_in.size  = req_size;
        req_in.sgn   = req_signed;
        req_in.addr  = req_addr;
        req_in.wdata = req_wdata;
    end

    // Outputs are registered from the next state, so the accept edge already drives ACCESS strobes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = '0;
        ram_sel_d    = '0;
        ram_data_d   = '0;

        cur = (state_q == S_IDLE) ? req_in : req_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_d = req_in;
                    if (is_bad(req_in.size, req_in.addr[1:0])) begin
                        state_d    = S_RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (!req_q.we) begin
                        resp_rdata_d = load_extract(ram_data_i, req_q.size, req_q.addr[1:0], req_q.sgn);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        ram_ce_d     = (state_d == S_ACCESS);

        if (ram_ce_d) begin
            ram_we_d   = cur.we;
            ram_addr_d = {cur.addr[AW-1:2], 2'b00};
            ram_sel_d  = lane_sel(cur.size, cur.addr[1:0]);
            ram_data_d = lane_data(cur.size, cur.wdata);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_sel_q    <= '0;
            ram_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_ce_q     <= ram_ce_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_sel_q    <= ram_sel_d;
            ram_data_q   <= ram_data_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_ce     = ram_ce_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_sel    = ram_sel_q;
    assign ram_data_o = ram_data_q;

    // Pipeline freeze request: combinational so the response cycle releases ctrl immediately.
    assign stall_req = req_valid & ~resp_valid_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: two instances (0 and 3 wait states) share one RAM
// model; expected responses come from a byte-addressed big-endian memory model.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        tb_valid = 1'b0;
    logic        use3 = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        rv0, rv3;
    assign rv0 = tb_valid & ~use3;
    assign rv3 = tb_valid & use3;

    logic        rr0, vld0, re0, st0, ce0, we0;
    logic        rr3, vld3, re3, st3, ce3, we3;
    logic [31:0] rd0, ad0, dt0, rd3, ad3, dt3;
    logic [3:0]  sl0, sl3;
    logic [31:0] ram_rd;

    data_mem_ctrl #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rr0), .resp_valid(vld0), .resp_rdata(rd0), .resp_err(re0),
        .stall_req(st0), .ram_ce(ce0), .ram_we(we0), .ram_addr(ad0), .ram_sel(sl0),
        .ram_data_o(dt0), .ram_data_i(ram_rd)
    );

    data_mem_ctrl #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rr3), .resp_valid(vld3), .resp_rdata(rd3), .resp_err(re3),
        .stall_req(st3), .ram_ce(ce3), .ram_we(we3), .ram_addr(ad3), .ram_sel(sl3),
        .ram_data_o(dt3), .ram_data_i(ram_rd)
    );

    // The idle instance drives zeros, so OR-merging yields the active instance's view.
    logic        m_vld, m_err, m_stall, m_ce, m_we;
    logic [31:0] m_rdata, m_addr, m_data;
    logic [3:0]  m_sel;
    assign m_vld   = vld0 | vld3;
    assign m_err   = re0 | re3;
    assign m_stall = st0 | st3;
    assign m_ce    = ce0 | ce3;
    assign m_we    = we0 | we3;
    assign m_rdata = rd0 | rd3;
    assign m_addr  = ad0 | ad3;
    assign m_data  = dt0 | dt3;
    assign m_sel   = sl0 | sl3;

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // RAM with combinational read and byte-lane writes on the clock edge.
    logic [31:0] ram [0:255];
    logic        ram_init = 1'b0;
    assign ram_rd = ram[m_addr[9:2]];

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed_word(i);
            ram_init <= 1'b1;
        end else if (m_ce && m_we) begin
            for (int j = 0; j < 4; j++)
                if (m_sel[j]) ram[m_addr[9:2]][8*j +: 8] <= m_data[8*j +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        int          ce_cycles;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } exp_t;

    exp_t sbq[$];
    int   resp_seen = 0;
    int   ce_cnt = 0;

    // Byte-addressed reference memory: address a holds the byte at RAM lane (a mod 4) from the MSB.
    logic [7:0] ref_bytes [0:1023];

    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input int ws, output exp_t e);
        int unsigned n, off, base, v;
        n    = 1 << size;
        off  = addr % 4;
        base = addr % 1024;
        e.we    = we;
        e.addr  = addr - off;
        e.rdata = '0;
        e.sel   = '0;
        e.wdata = '0;
        e.err   = (size == 2'b11) || ((off % n) != 0);
        e.cyc   = cyc + (e.err ? 1 : ws + 2);
        e.ce_cycles = e.err ? 0 : ws + 1;
        if (e.err) return;
        for (int unsigned i = 0; i < n; i++) e.sel[3 - (off + i)] = 1'b1;
        for (int unsigned j = 0; j < 4; j++)
            e.wdata = e.wdata | (((wdata >> (8 * (n - 1 - (j % n)))) & 32'hFF) << (8 * (3 - j)));
        if (we) begin
            for (int unsigned i = 0; i < n; i++)
                ref_bytes[base + i] = 8'((wdata >> (8 * (n - 1 - i))) & 32'hFF);
        end else begin
            v = 0;
            for (int unsigned i = 0; i < n; i++) v = (v << 8) | 32'(ref_bytes[base + i]);
            if (sgn && n < 4 && v >= (32'd1 << (8 * n - 1)))
                v = v | ~((32'd1 << (8 * n)) - 1);
            e.rdata = v;
        end
    endfunction

    // Monitor: stall, RAM strobes and responses against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_stall;
            exp_stall = tb_valid && !(sbq.size() > 0 && sbq[0].cyc == cyc);
            check("stall_req", 32'(m_stall), 32'(exp_stall));
        end
        if (rst) ce_cnt = 0;
        else if (m_ce) begin
            ce_cnt++;
            if (sbq.size() > 0 && !sbq[0].err) begin
                check("ram_addr", m_addr, sbq[0].addr);
                check("ram_sel", 32'(m_sel), 32'(sbq[0].sel));
                check("ram_we", 32'(m_we), 32'(sbq[0].we));
                if (sbq[0].we) check("ram_data_o", m_data, sbq[0].wdata);
            end
        end
        if (m_vld) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
                check("resp_rdata", m_rdata, e.rdata);
                check("resp_err", 32'(m_err), 32'(e.err));
                check("ce_cycles", 32'(ce_cnt), 32'(e.ce_cycles));
            end
            ce_cnt = 0;
            resp_seen++;
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   target, n;
        @(posedge clk); #1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        tb_valid   = 1'b1;
        check("req_ready", 32'(use3 ? rr3 : rr0), 32'd1);
        model(we, size, sgn, addr, wdata, use3 ? 3 : 0, e);
        sbq.push_back(e);
        target = resp_seen + 1;
        n = 0;
        while (resp_seen < target && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (resp_seen < target) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no resp_valid within 40 cycles for addr 0x%08h", addr);
            sbq.delete();
        end
    endtask

    task automatic go_idle(input int cycles);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic check_quiet(input string tag, input logic rr, input logic vld,
                               input logic [31:0] rd, input logic re, input logic ce,
                               input logic we, input logic [31:0] ad, input logic [3:0] sl,
                               input logic [31:0] dt);
        check({tag, "_req_ready"}, 32'(rr), 32'd1);
        check({tag, "_resp_valid"}, 32'(vld), 32'd0);
        check({tag, "_resp_rdata"}, rd, 32'd0);
        check({tag, "_resp_err"}, 32'(re), 32'd0);
        check({tag, "_ram_ce"}, 32'(ce), 32'd0);
        check({tag, "_ram_we"}, 32'(we), 32'd0);
        check({tag, "_ram_addr"}, ad, 32'd0);
        check({tag, "_ram_sel"}, 32'(sl), 32'd0);
        check({tag, "_ram_data_o"}, dt, 32'd0);
    endtask

    task automatic random_ops(input int count);
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        for (int k = 0; k < count; k++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            a  = $urandom();
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = seed_word(i);
            ref_bytes[4*i]     = w[31:24];
            ref_bytes[4*i + 1] = w[23:16];
            ref_bytes[4*i + 2] = w[15:8];
            ref_bytes[4*i + 3] = w[7:0];
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("rst0", rr0, vld0, rd0, re0, ce0, we0, ad0, sl0, dt0);
        check_quiet("rst3", rr3, vld3, rd3, re3, ce3, we3, ad3, sl3, dt3);
        check("rst_stall", 32'(m_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero wait states: word round trip, extension cases, byte store, error cases.
        use3 = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1122_3344);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h80FF_7F01);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0104, 32'h0000_0041);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'hFFFF_FFFF);
        random_ops(40);
        go_idle(2);

        // Three wait states: stretched access, then reset during ACCESS.
        use3 = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h0000_A5C3);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0043, 32'h0);
        go_idle(1);

        @(posedge clk); #1;
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h0000_0040;
        tb_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tb_valid = 1'b0;
        @(negedge clk);
        check_quiet("abort3", rr3, vld3, rd3, re3, ce3, we3, ad3, sl3, dt3);
        check("abort_stall", 32'(m_stall), 32'd0);
        repeat (6) @(posedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        random_ops(40);
        go_idle(3);

        for (int i = 0; i < 256; i++)
            check("ram_image", ram[i], {ref_bytes[4*i], ref_bytes[4*i + 1],
                                        ref_bytes[4*i + 2], ref_bytes[4*i + 3]});
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL outstanding: %0d responses never arrived, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
